jpeg_fb_writer: RTL and testbench
=================================

Name: jpeg_fb_writer

Overview:
Sequences the pixel output of jpeg_top into a linear raster frame buffer. It consumes the MCU-ordered pixel stream (we/next handshake, begin/end framing, in-MCU index, MCU x/y) and converts each pixel to a raster word address. It issues single-pixel writes to a memory port that can apply backpressure, and reports frame completion. It sits between jpeg_top's b-port and the frame-buffer memory, configured from jpeg_top's c-port.

Parameters:
ADDR_W, 24, width of frame-buffer word address (one 24-bit RGB pixel per word)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ci_en  in  1  header valid from decoder; arms the writer
ci_411  in  1  1: 16x16 MCU; 0: 8x8 MCU
ci_width  in  16  image width in pixels
ci_heigth  in  16  image height in pixels
ci_stride  in  16  frame-buffer line pitch in words
ci_base  in  ADDR_W  frame-buffer base word address
bi_we  in  1  decoder pixel valid
bo_next  out  1  writer accepts pixel this cycle
bi_begin  in  1  first pixel of frame
bi_end  in  1  last pixel of frame
bi_r, bi_g, bi_b  in  8 each  pixel colour
bi_adr  in  8  pixel index inside MCU
bi_x_mcu, bi_y_mcu  in  13 each  MCU column/row
mo_we  out  1  memory write request
mi_ready  in  1  memory accepts write this cycle
mo_adr  out  ADDR_W  write word address
mo_data  out  24  {r,g,b}
so_busy  out  1  state != IDLE
so_done  out  1  one-cycle pulse: frame fully written
so_pix_cnt  out  32  pixels written this frame

Behaviour:
- Reset: state IDLE, pipeline empty; bo_next=0, mo_we=0, mo_adr=0, mo_data=0, so_busy=0, so_done=0, so_pix_cnt=0.
- Transfer: pixel accepted when bi_we & bo_next; memory write completes when mo_we & mi_ready.
- FSM: IDLE -> ARMED when ci_en=1 (latch ci_411/width/heigth/stride/base; clear so_pix_cnt). ARMED: bo_next=1; accepted pixels without bi_begin are discarded; accepted pixel with bi_begin -> RUN and that pixel is processed. RUN: process every accepted pixel; accepting pixel with bi_end -> DRAIN. Pixel with both bi_begin and bi_end in ARMED -> DRAIN directly. DRAIN: bo_next=0 until pipeline empty, then DONE. DONE: so_done=1 for one cycle -> IDLE. bi_begin seen in RUN is treated as a normal pixel.
- Coordinates: 411: row=bi_adr[7:4], col=bi_adr[3:0], x=x_mcu*16+col, y=y_mcu*16+row. 444: row=bi_adr[5:3], col=bi_adr[2:0], x=x_mcu*8+col, y=y_mcu*8+row; bi_adr[7:6] ignored.
- Address: mo_adr = ci_base + y*ci_stride + x, computed in 32 bits, truncated to ADDR_W (wraps silently).
- Pipeline: 2 stages (S1: x,y and y*stride product; S2: add, output register). Latency: pixel accepted in cycle N is presented on mo_we at cycle N+2 with no stall.
- Stall: S2 holds while mo_we & !mi_ready; S1 advances only if S2 empty or draining. bo_next (RUN/ARMED) = !(S1 valid & S2 stalled). mo_adr/mo_data stable while mo_we & !mi_ready.
- so_pix_cnt increments per completed memory write; holds after DONE until next arming.
- Simultaneous bo_next accept and S2 drain in the same cycle: sustains 1 pixel/cycle throughput when mi_ready=1.
- rst mid-frame: pipeline flushed, no further mo_we, returns to IDLE; in-flight pixels are lost.
- ci_en held high through DONE re-arms on the next cycle after returning to IDLE.

Optional Feature:
JPEG_FBW_CLIP_EN: defined -> pixels with x>=ci_width or y>=ci_heigth (MCU padding) are consumed but produce no mo_we and are not counted. Undefined -> every processed pixel is written, including padding; stride must cover padded width.

Test Plan:
- 411, base=0x1000, stride=32, width=32, heigth=16, mi_ready=1; pixel begin, x_mcu=0,y_mcu=0,adr=0x11 -> mo_we at +2 cycles, mo_adr=0x1021; adr=0xFF, x_mcu=1 -> mo_adr=0x11FF.
- 444, base=0, stride=24; x_mcu=2,y_mcu=1,adr=0x2D (row5,col5) -> mo_adr=13*24+21=0x14D; adr=0xED gives same address.
- Backpressure: continuous bi_we, mi_ready low 5 cycles -> bo_next low within 1 cycle, mo_adr/mo_data stable, no pixel lost or duplicated; 512-pixel 411 frame -> so_pix_cnt=512, so_done one pulse.
- ARMED filtering: 3 pixels without bi_begin, then begin frame of 256 pixels -> exactly 256 writes; so_done 1 cycle after last mi_ready handshake.
- Clip (JPEG_FBW_CLIP_EN): 411, width=20, heigth=16, 2 MCUs -> pixels with x>=20 not written, so_pix_cnt=320; macro undefined -> 512.
- rst asserted mid-RUN with stalled S2 -> next cycle mo_we=0, so_busy=0; new ci_en frame writes correctly.

Source files
------------

// File: rtl/jpeg_fb_writer.sv
// jpeg_fb_writer: converts jpeg_top's MCU-ordered pixel stream into raster frame-buffer writes.
// Optional JPEG_FBW_CLIP_EN drops MCU padding pixels outside ci_width x ci_heigth.
module jpeg_fb_writer #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ci_en,
    input  logic              ci_411,
    input  logic [15:0]       ci_width,
    input  logic [15:0]       ci_heigth,
    input  logic [15:0]       ci_stride,
    input  logic [ADDR_W-1:0] ci_base,
    input  logic              bi_we,
    output logic              bo_next,
    input  logic              bi_begin,
    input  logic              bi_end,
    input  logic [7:0]        bi_r,
    input  logic [7:0]        bi_g,
    input  logic [7:0]        bi_b,
    input  logic [7:0]        bi_adr,
    input  logic [12:0]       bi_x_mcu,
    input  logic [12:0]       bi_y_mcu,
    output logic              mo_we,
    input  logic              mi_ready,
    output logic [ADDR_W-1:0] mo_adr,
    output logic [23:0]       mo_data,
    output logic              so_busy,
    output logic              so_done,
    output logic [31:0]       so_pix_cnt
);
    typedef enum logic [2:0] {IDLE, ARMED, RUN, DRAIN, DONE} state_e;
    state_e state_q, state_d;
    logic              cfg_411_q;
    logic [15:0]       cfg_stride_q;
    logic [ADDR_W-1:0] cfg_base_q;
    logic              s1_v_q;
    logic [31:0]       s1_x_q, s1_p_q;
    logic [23:0]       s1_d_q;
    logic              mo_we_q;
    logic [ADDR_W-1:0] mo_adr_q;
    logic [23:0]       mo_data_q;
    logic [31:0]       pix_cnt_q;
    logic              s2_stall, s1_en, accept, take, keep, arm;
    logic [31:0]       x, y, prod;

    assign arm      = (state_q == IDLE) & ci_en;
    assign s2_stall = mo_we_q & ~mi_ready;
    assign s1_en    = ~(s1_v_q & s2_stall);
    assign accept   = bi_we & bo_next;
    assign take     = accept & ((state_q == RUN) | bi_begin);
    assign x = cfg_411_q ? {15'd0, bi_x_mcu, bi_adr[3:0]} : {16'd0, bi_x_mcu, bi_adr[2:0]};
    assign y = cfg_411_q ? {15'd0, bi_y_mcu, bi_adr[7:4]} : {16'd0, bi_y_mcu, bi_adr[5:3]};
    assign prod = y * {16'd0, cfg_stride_q};

`ifdef JPEG_FBW_CLIP_EN
    logic [15:0] cfg_w_q, cfg_h_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_w_q <= '0;
            cfg_h_q <= '0;
        end else if (arm) begin
            cfg_w_q <= ci_width;
            cfg_h_q <= ci_heigth;
        end
    end
    assign keep = (x < {16'd0, cfg_w_q}) & (y < {16'd0, cfg_h_q});
`else
    logic unused_dim;
    assign unused_dim = ^{ci_width, ci_heigth};
    assign keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ci_en ? ARMED : IDLE;
            ARMED:   state_d = (accept & bi_begin) ? (bi_end ? DRAIN : RUN) : ARMED;
            RUN:     state_d = (accept & bi_end) ? DRAIN : RUN;
            // Leave DRAIN as the last write handshakes so so_done follows it by one cycle
            DRAIN:   state_d = (~s1_v_q & (~mo_we_q | mi_ready)) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bo_next = ((state_q == ARMED) | (state_q == RUN)) & s1_en;
        so_busy = state_q != IDLE;
        so_done = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_411_q    <= 1'b0;
            cfg_stride_q <= '0;
            cfg_base_q   <= '0;
            s1_v_q       <= 1'b0;
            s1_x_q       <= '0;
            s1_p_q       <= '0;
            s1_d_q       <= '0;
            mo_we_q      <= 1'b0;
            mo_adr_q     <= '0;
            mo_data_q    <= '0;
            pix_cnt_q    <= '0;
        end else begin
            if (arm) begin
                cfg_411_q    <= ci_411;
                cfg_stride_q <= ci_stride;
                cfg_base_q   <= ci_base;
            end
            if (s1_en) begin
                s1_v_q <= take & keep;
                s1_x_q <= x;
                s1_p_q <= prod;
                s1_d_q <= {bi_r, bi_g, bi_b};
            end
            if (~s2_stall) begin
                mo_we_q   <= s1_v_q;
                mo_adr_q  <= ADDR_W'(32'(cfg_base_q) + s1_p_q + s1_x_q);
                mo_data_q <= s1_d_q;
            end
            pix_cnt_q <= arm ? 32'd0 : pix_cnt_q + {31'd0, mo_we_q & mi_ready};
        end
    end

    assign mo_we      = mo_we_q;
    assign mo_adr     = mo_adr_q;
    assign mo_data    = mo_data_q;
    assign so_pix_cnt = pix_cnt_q;
endmodule

// File: tb/tb_jpeg_fb_writer.sv
// tb_jpeg_fb_writer: directed address vectors plus randomized frames checked against a raster model.
module tb_jpeg_fb_writer;
    localparam int AW = 24;
    logic          clk = 0, rst = 1, ci_en = 0, ci_411 = 0;
    logic [15:0]   ci_width = 0, ci_heigth = 0, ci_stride = 0;
    logic [AW-1:0] ci_base = 0;
    logic          bi_we = 0, bi_begin = 0, bi_end = 0, mi_ready = 1;
    logic [7:0]    bi_r = 0, bi_g = 0, bi_b = 0, bi_adr = 0;
    logic [12:0]   bi_x_mcu = 0, bi_y_mcu = 0;
    logic          bo_next, mo_we, so_busy, so_done;
    logic [AW-1:0] mo_adr;
    logic [23:0]   mo_data;
    logic [31:0]   so_pix_cnt;

    jpeg_fb_writer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ci_en(ci_en), .ci_411(ci_411), .ci_width(ci_width),
        .ci_heigth(ci_heigth), .ci_stride(ci_stride), .ci_base(ci_base), .bi_we(bi_we),
        .bo_next(bo_next), .bi_begin(bi_begin), .bi_end(bi_end), .bi_r(bi_r), .bi_g(bi_g),
        .bi_b(bi_b), .bi_adr(bi_adr), .bi_x_mcu(bi_x_mcu), .bi_y_mcu(bi_y_mcu), .mo_we(mo_we),
        .mi_ready(mi_ready), .mo_adr(mo_adr), .mo_data(mo_data), .so_busy(so_busy),
        .so_done(so_done), .so_pix_cnt(so_pix_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, last_hs = -100, done_cnt = 0, rdy_mode = 0;
    bit bp_chk_en = 0, prev_stall = 0, prev_acc = 0;
    logic [AW-1:0] prev_adr;
    logic [23:0]   prev_data;
    logic [47:0]   obs_q[$], exp_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) mi_ready = ($urandom_range(0, 3) != 0);
        else if (rdy_mode == 2) mi_ready = ((cyc % 16) >= 5);
    end

    // Write monitor: collects handshakes and checks output stability under backpressure
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
            prev_acc = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_we", mo_we, 1);
                chk("stall_adr", mo_adr, prev_adr);
                chk("stall_data", mo_data, prev_data);
                if (bp_chk_en && prev_acc && mo_we && !mi_ready) chk("bp_next", bo_next, 0);
            end
            if (mo_we && mi_ready) begin
                obs_q.push_back({mo_adr, mo_data});
                last_hs = cyc;
            end
            if (so_done) begin
                done_cnt++;
                chk("done_latency", cyc - last_hs, 1);
            end
            prev_stall = mo_we & !mi_ready;
            prev_acc = bi_we & bo_next;
            prev_adr = mo_adr;
            prev_data = mo_data;
        end
    end

    function automatic logic [AW-1:0] ref_adr(bit is411, logic [15:0] stride, logic [AW-1:0] base,
                                              int xm, int ym, int adr, output longint x, output longint y);
        longint s = is411 ? 16 : 8;
        x = xm * s + adr % s;
        y = ym * s + (is411 ? adr / 16 : (adr / 8) % 8);
        return AW'((longint'(base) + y * longint'(stride) + x) % (longint'(1) << AW));
    endfunction

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(bit is411, logic [15:0] w, logic [15:0] h, logic [15:0] stride, logic [AW-1:0] base);
        ci_411 = is411; ci_width = w; ci_heigth = h; ci_stride = stride; ci_base = base; ci_en = 1;
        cyc1();
        ci_en = 0;
        chk("armed_busy", so_busy, 1);
        chk("armed_cnt", so_pix_cnt, 0);
    endtask

    task automatic send_pix(bit b, bit e, int xm, int ym, logic [7:0] adr, logic [23:0] d, int gap);
        bit acc = 0;
        int n = 0;
        repeat (gap) cyc1();
        bi_we = 1; bi_begin = b; bi_end = e; bi_adr = adr;
        bi_x_mcu = 13'(xm); bi_y_mcu = 13'(ym); {bi_r, bi_g, bi_b} = d;
        while (!acc) begin
            @(negedge clk);
            acc = bo_next;
            cyc1();
            if (++n > 2000) begin
                $display("FAIL accept_timeout: pixel not accepted after %0d cycles", n);
                $fatal(1, "timeout");
            end
        end
        bi_we = 0; bi_begin = 0; bi_end = 0;
    endtask

    task automatic run_frame(bit is411, logic [15:0] w, logic [15:0] h, logic [15:0] stride,
                             logic [AW-1:0] base, int nx, int ny, int njunk, int maxgap);
        int mpx = is411 ? 256 : 64, total = nx * ny * mpx, k = 0, n = 0, d0, mism = 0;
        longint px, py;
        arm(is411, w, h, stride, base);
        exp_q.delete();
        obs_q.delete();
        d0 = done_cnt;
        for (int j = 0; j < njunk; j++)
            send_pix(0, 0, $urandom_range(0, 7), 0, 8'($urandom), 24'($urandom), 0);
        for (int my = 0; my < ny; my++)
            for (int mx = 0; mx < nx; mx++)
                for (int i = 0; i < mpx; i++) begin
                    logic [7:0]    a = is411 ? 8'(i) : {2'($urandom), 6'(i)};
                    logic [23:0]   d = 24'($urandom);
                    logic [AW-1:0] ea = ref_adr(is411, stride, base, mx, my, int'(a), px, py);
`ifdef JPEG_FBW_CLIP_EN
                    if (px < w && py < h) exp_q.push_back({ea, d});
`else
                    exp_q.push_back({ea, d});
`endif
                    send_pix(k == 0, k == total - 1, mx, my, a, d, $urandom_range(0, maxgap));
                    k++;
                end
        while (!so_done && n < 5000) begin
            cyc1();
            n++;
        end
        chk("done_seen", so_done, 1);
        chk("pix_cnt", so_pix_cnt, exp_q.size());
        chk("write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) mism++;
        chk("write_seq_mismatches", mism, 0);
        cyc1();
        chk("done_pulse", so_done, 0);
        chk("done_once", done_cnt - d0, 1);
        chk("idle_busy", so_busy, 0);
        chk("cnt_hold", so_pix_cnt, exp_q.size());
    endtask

    typedef struct {
        bit            is411;
        logic [15:0]   stride;
        logic [AW-1:0] base;
        int            xm, ym;
        logic [7:0]    adr;
        logic [23:0]   rgb;
        logic [AW-1:0] exp_adr;
    } vec_t;
    vec_t vt[6];

    initial begin
        vt[0] = '{1, 16'd32,     24'h001000, 0,      0,      8'h11, 24'h112233, 24'h001021};
        vt[1] = '{1, 16'd32,     24'h001000, 1,      0,      8'hFF, 24'hA5A5A5, 24'h0011FF};
        vt[2] = '{0, 16'd24,     24'h000000, 2,      1,      8'h2D, 24'h0F1E2D, 24'h00014D};
        vt[3] = '{0, 16'd24,     24'h000000, 2,      1,      8'hED, 24'hFFFFFF, 24'h00014D};
        vt[4] = '{1, 16'h0100,   24'hFFFFFF, 0,      0,      8'h12, 24'h000001, 24'h000101};
        vt[5] = '{0, 16'hFFFF,   24'h123456, 'h1000, 'h1000, 8'h3F, 24'h800000, 24'h193456};

        repeat (3) cyc1();
        chk("rst_next", bo_next, 0);
        chk("rst_we", mo_we, 0);
        chk("rst_adr", mo_adr, 0);
        chk("rst_data", mo_data, 0);
        chk("rst_busy", so_busy, 0);
        chk("rst_done", so_done, 0);
        chk("rst_cnt", so_pix_cnt, 0);
        rst = 0;
        cyc1();

        foreach (vt[i]) begin
            arm(vt[i].is411, 16'hFFFF, 16'hFFFF, vt[i].stride, vt[i].base);
            bi_we = 1; bi_begin = 1; bi_end = 1; bi_adr = vt[i].adr;
            bi_x_mcu = 13'(vt[i].xm); bi_y_mcu = 13'(vt[i].ym); {bi_r, bi_g, bi_b} = vt[i].rgb;
            chk("vec_next", bo_next, 1);
            cyc1();
            bi_we = 0; bi_begin = 0; bi_end = 0;
            chk("vec_we_n1", mo_we, 0);
            cyc1();
            chk("vec_we_n2", mo_we, 1);
            chk("vec_adr", mo_adr, vt[i].exp_adr);
            chk("vec_data", mo_data, vt[i].rgb);
            cyc1();
            chk("vec_done", so_done, 1);
            chk("vec_cnt", so_pix_cnt, 1);
            cyc1();
            chk("vec_done_clr", so_done, 0);
            chk("vec_idle", so_busy, 0);
        end

        rdy_mode = 2; bp_chk_en = 1;
        run_frame(1, 16'd32, 16'd16, 16'd32, 24'h001000, 2, 1, 0, 0);
        bp_chk_en = 0; rdy_mode = 1;
        run_frame(1, 16'd20, 16'd16, 16'd32, AW'($urandom), 2, 1, 0, 2);
        rdy_mode = 0; mi_ready = 1;
        run_frame(1, 16'd16, 16'd16, 16'd16, AW'($urandom), 1, 1, 3, 0);
        rdy_mode = 1;
        run_frame(0, 16'd20, 16'd12, 16'd24, AW'($urandom), 3, 2, 2, 1);

        rdy_mode = 0; mi_ready = 0;
        arm(1, 16'd32, 16'd16, 16'd32, 24'h002000);
        bi_we = 1; bi_begin = 1; bi_adr = 0; bi_x_mcu = 0; bi_y_mcu = 0;
        for (int i = 0; i < 3; i++) begin
            cyc1();
            bi_begin = 0;
            bi_adr = bi_adr + 1;
        end
        chk("pre_rst_we", mo_we, 1);
        chk("pre_rst_next", bo_next, 0);
        rst = 1; bi_we = 0;
        cyc1();
        chk("mid_rst_we", mo_we, 0);
        chk("mid_rst_busy", so_busy, 0);
        chk("mid_rst_next", bo_next, 0);
        rst = 0; mi_ready = 1;
        cyc1();
        chk("post_rst_we", mo_we, 0);
        chk("post_rst_busy", so_busy, 0);
        rdy_mode = 1;
        run_frame(0, 16'd16, 16'd8, 16'd16, AW'($urandom), 2, 1, 1, 1);
        rdy_mode = 0; mi_ready = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
